d16_uart: RTL and testbench

Memory-mapped 8N1 UART peripheral on the d16 CPU data bus, downstream of the CPU's bus master port. It decodes a 4-word window, returns read data combinationally in the same cycle, and latches writes on the clock edge. It holds 4-entry TX and RX FIFOs and raises an interrupt-request level to drive the CPU's `i_int` input. The CPU bus has no acknowledge and no read strobe, so every register read is side-effect free.

---
 rtl/d16_uart.sv | 267 ++++++++++++++++++++++++++
 tb/tb_d16_uart.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/d16_uart.sv
// d16_uart: memory-mapped 8N1 UART on the d16 data bus with 4-entry TX/RX FIFOs.
// Map: 0 DATA, 1 STATUS, 2 DIV, 3 reserved; o_irq follows RX FIFO non-empty.

module d16_uart_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned W  = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    // Fullness is judged before the edge, so a pop cannot make room for a same-edge push.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rp];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
endmodule

module d16_uart #(
    parameter logic [15:0] BASE      = 16'hFF00,
    parameter logic [15:0] DIV_RESET = 16'd103,
    parameter int unsigned FIFO_AW   = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_wb_addr,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_dat,
    output logic [15:0] o_wb_dat,
    output logic        o_sel,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_irq
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        w_wr, w_wr_data, w_wr_stat, w_wr_div;
    logic [15:0] r_div;
    logic        r_tx_ovf, r_rx_ovr, r_rx_ferr;
    logic        w_tx_pop, w_tx_empty, w_tx_full, w_tx_done;
    logic [7:0]  w_tx_head;
    logic        w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
    logic        w_rx_ovr_set, w_rx_ferr_set;
    logic [7:0]  w_rx_head;

    tx_state_t   r_tx_state, w_tx_next;
    logic [15:0] r_tx_ctr;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        w_tx_tick;

    rx_state_t   r_rx_state, w_rx_next;
    logic [15:0] r_rx_ctr;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic        w_rx_tick, w_rx_fall;

    assign o_sel     = (i_wb_addr[15:2] == BASE[15:2]);
    assign w_wr      = i_wb_cyc & i_wb_we & o_sel;
    assign w_wr_data = w_wr & (i_wb_addr[1:0] == 2'd0);
    assign w_wr_stat = w_wr & (i_wb_addr[1:0] == 2'd1);
    assign w_wr_div  = w_wr & (i_wb_addr[1:0] == 2'd2);
    assign w_rx_pop  = w_wr_stat & i_wb_dat[0];
    assign w_tx_done = w_tx_empty & (r_tx_state == TX_IDLE);
    assign o_irq     = ~w_rx_empty;

    always_comb begin
        o_wb_dat = '0;
        if (o_sel) begin
            case (i_wb_addr[1:0])
                2'd0:    o_wb_dat = {8'h00, w_rx_empty ? 8'h00 : w_rx_head};
                2'd1:    o_wb_dat = {10'd0, r_tx_ovf, r_rx_ferr, r_rx_ovr,
                                     w_tx_done, w_tx_full, ~w_rx_empty};
                2'd2:    o_wb_dat = r_div;
                default: o_wb_dat = '0;
            endcase
        end
    end

    d16_uart_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_wr_data),
        .i_pop   (w_tx_pop),
        .i_data  (i_wb_dat[7:0]),
        .o_data  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    d16_uart_fifo #(.AW(FIFO_AW), .W(8)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_data  (r_rx_shift),
        .o_data  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div     <= DIV_RESET;
            r_tx_ovf  <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_rx_ferr <= 1'b0;
        end else begin
            if (w_wr_div) r_div <= (i_wb_dat < 16'd2) ? 16'd2 : i_wb_dat;
            r_tx_ovf  <= (w_wr_data & w_tx_full) | (r_tx_ovf & ~(w_wr_stat & i_wb_dat[5]));
            r_rx_ovr  <= w_rx_ovr_set | (r_rx_ovr & ~(w_wr_stat & i_wb_dat[3]));
            r_rx_ferr <= w_rx_ferr_set | (r_rx_ferr & ~(w_wr_stat & i_wb_dat[4]));
        end
    end

    // TX: the pop that starts a frame also happens straight out of STOP for gapless streams.
    assign w_tx_tick = (r_tx_ctr == '0);
    assign w_tx_pop  = ~w_tx_empty &
                       ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_tick));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_tx_state <= TX_IDLE;
        else         r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (!w_tx_empty) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = w_tx_empty ? TX_IDLE : TX_START;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        case (r_tx_state)
            TX_START: o_tx = 1'b0;
            TX_DATA:  o_tx = r_tx_shift[0];
            default:  o_tx = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_ctr   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '1;
        end else if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_ctr   <= r_div;
            r_tx_bit   <= '0;
        end else if (r_tx_state != TX_IDLE) begin
            if (w_tx_tick) begin
                r_tx_ctr <= r_div;
                if (r_tx_state == TX_DATA) begin
                    r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_ctr <= r_tx_ctr - 16'd1;
            end
        end
    end

    // RX: 2-flop synchronizer plus one flop for falling-edge detection.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= i_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx_fall    = r_rx_prev & ~r_rx_s2;
    assign w_rx_tick    = (r_rx_ctr == '0);
    assign w_rx_ovr_set = w_rx_push & w_rx_full;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_rx_state <= RX_IDLE;
        else         r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_push     = 1'b0;
        w_rx_ferr_set = 1'b0;
        if (r_rx_state == RX_STOP && w_rx_tick) begin
            w_rx_push     = r_rx_s2;
            w_rx_ferr_set = ~r_rx_s2;
        end
    end

    // Loading DIV>>1 minus one while idle puts the start sample DIV>>1 cycles into START.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_ctr   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else if (r_rx_state == RX_IDLE) begin
            r_rx_ctr <= {1'b0, r_div[15:1]} - 16'd1;
            r_rx_bit <= '0;
        end else if (w_rx_tick) begin
            r_rx_ctr <= r_div;
            if (r_rx_state == RX_DATA) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end else begin
            r_rx_ctr <= r_rx_ctr - 16'd1;
        end
    end
endmodule

// File: tb/tb_d16_uart.sv
// Directed bench for d16_uart: register map, TX framing/streaming, RX framing,
// FIFO overflow, sticky flags, glitch rejection and mid-frame reset.

module tb_d16_uart;
    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        cyc;
    logic        we;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic        sel;
    logic        rx;
    logic        tx;
    logic        irq;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        irq_pre;
    logic [15:0] d;

    d16_uart #(.BASE(16'hFF00), .DIV_RESET(16'd103), .FIFO_AW(2)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_wb_addr (addr),
        .i_wb_cyc  (cyc),
        .i_wb_we   (we),
        .i_wb_dat  (wdat),
        .o_wb_dat  (rdat),
        .o_sel     (sel),
        .i_rx      (rx),
        .o_tx      (tx),
        .o_irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        addr = a; wdat = v; cyc = 1'b1; we = 1'b1;
        tick();
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        addr = a; cyc = 1'b0; we = 1'b0;
        #1;
        v = rdat;
    endtask

    // Expected line level p cycles into a 4-cycle-per-bit frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int p);
        int slot;
        slot = p / 4;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Drives one frame at 4 cycles per bit starting just after the current edge.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        for (int t = 0; t < 40; t++) begin
            if (t < 36) rx = frame_bit(b, t);
            else        rx = stop;
            tick();
            if (t == 38) irq_pre = irq;
        end
        rx = 1'b1;
    endtask

    logic [7:0] tx_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] rx_bytes [5] = '{8'h01, 8'h82, 8'h7E, 8'hC4, 8'h39};
    logic [15:0] div_in  [5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0005, 16'hFFFF};
    logic [15:0] div_out [5] = '{16'h0002, 16'h0002, 16'h0002, 16'h0005, 16'hFFFF};

    initial begin
        rst = 1'b1; addr = '0; cyc = 1'b0; we = 1'b0; wdat = '0; rx = 1'b1;
        irq_pre = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        rd(16'hFF01, d); chk("reset_status", d, 16'h0004);
        rd(16'hFF02, d); chk("reset_div", d, 16'd103);
        chk("reset_tx", 16'(tx), 16'h0001);
        chk("reset_irq", 16'(irq), 16'h0000);
        rd(16'hFF03, d); chk("rsvd_read", d, 16'h0000);
        chk("rsvd_sel", 16'(sel), 16'h0001);
        rd(16'hFE00, d); chk("nosel_data", d, 16'h0000);
        chk("nosel_sel", 16'(sel), 16'h0000);

        // Single TX frame of 0x55 at DIV=3.
        wr(16'hFF02, 16'd3);
        rd(16'hFF02, d); chk("div3", d, 16'd3);
        wr(16'hFF00, 16'h0155);
        for (int k = 1; k <= 44; k++) begin
            tick();
            chk($sformatf("tx1 k=%0d", k), 16'(tx),
                16'((k <= 40) ? frame_bit(8'h55, k - 1) : 1'b1));
            if (k == 40) begin rd(16'hFF01, d); chk("tx1_busy40", d, 16'h0000); end
            if (k == 41) begin rd(16'hFF01, d); chk("tx1_done41", d, 16'h0004); end
        end

        // The first byte is popped one edge after its write, so six writes overflow.
        for (int i = 0; i < 6; i++) begin
            addr = 16'hFF00; wdat = 16'(8'h11 * (i + 1)); cyc = 1'b1; we = 1'b1;
            tick();
        end
        cyc = 1'b0; we = 1'b0;
        rd(16'hFF01, d); chk("tx_ovf_status", d, 16'h0022);
        for (int k = 6; k <= 204; k++) begin
            tick();
            chk($sformatf("txs k=%0d", k), 16'(tx),
                16'((k <= 200) ? frame_bit(tx_bytes[(k - 1) / 40], (k - 1) % 40) : 1'b1));
            if (k == 200) begin rd(16'hFF01, d); chk("txs_busy200", d, 16'h0020); end
            if (k == 201) begin rd(16'hFF01, d); chk("txs_done201", d, 16'h0024); end
        end
        wr(16'hFF01, 16'h0020);
        rd(16'hFF01, d); chk("tx_ovf_clear", d, 16'h0004);

        // Single RX frame with latency check.
        tick(); tick();
        rx_frame(8'hA3, 1'b1);
        chk("rx_irq_pre", 16'(irq_pre), 16'h0000);
        chk("rx_irq", 16'(irq), 16'h0001);
        rd(16'hFF00, d); chk("rx_data", d, 16'h00A3);
        rd(16'hFF01, d); chk("rx_status", d, 16'h0005);
        wr(16'hFF01, 16'h0001);
        chk("rx_pop_irq", 16'(irq), 16'h0000);
        rd(16'hFF00, d); chk("rx_pop_data", d, 16'h0000);

        // RX overrun, framing error, glitch.
        for (int i = 0; i < 5; i++) begin
            tick(); tick();
            rx_frame(rx_bytes[i], 1'b1);
        end
        tick(); tick();
        rd(16'hFF01, d); chk("rx_ovr_status", d, 16'h000D);
        rx_frame(8'hFF, 1'b0);
        tick(); tick();
        rd(16'hFF01, d); chk("rx_ferr_status", d, 16'h001D);
        for (int i = 0; i < 4; i++) begin
            rd(16'hFF00, d); chk($sformatf("rx_order%0d", i), d, {8'h00, rx_bytes[i]});
            wr(16'hFF01, 16'h0001);
        end
        chk("rx_drained_irq", 16'(irq), 16'h0000);
        rd(16'hFF00, d); chk("rx_drained_data", d, 16'h0000);
        wr(16'hFF01, 16'h0018);
        rd(16'hFF01, d); chk("rx_flags_clear", d, 16'h0004);
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (60) tick();
        rd(16'hFF01, d); chk("glitch_status", d, 16'h0004);
        chk("glitch_irq", 16'(irq), 16'h0000);

        // Unselected write must not reach the TX FIFO.
        wr(16'hFE00, 16'h0041);
        rd(16'hFF01, d); chk("nosel_write", d, 16'h0004);

        // Mid-frame asynchronous reset with both FIFOs occupied.
        rx_frame(8'h5A, 1'b1);
        tick(); tick();
        wr(16'hFF00, 16'h0000);
        wr(16'hFF00, 16'h00FF);
        repeat (9) tick();
        chk("pre_reset_tx", 16'(tx), 16'h0000);
        chk("pre_reset_irq", 16'(irq), 16'h0001);
        rst = 1'b1;
        #2;
        chk("async_reset_tx", 16'(tx), 16'h0001);
        chk("async_reset_irq", 16'(irq), 16'h0000);
        tick();
        rst = 1'b0;
        rd(16'hFF01, d); chk("post_reset_status", d, 16'h0004);
        rd(16'hFF02, d); chk("post_reset_div", d, 16'd103);
        rd(16'hFF00, d); chk("post_reset_data", d, 16'h0000);
        repeat (3) tick();
        chk("post_reset_tx", 16'(tx), 16'h0001);

        for (int i = 0; i < 5; i++) begin
            wr(16'hFF02, div_in[i]);
            rd(16'hFF02, d); chk($sformatf("div_wr %h", div_in[i]), d, div_out[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
